// File: rtl/clk_gate_pkg.sv
// Shared definitions for the clock-gate enable controller: state encoding and counter width default.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clk_gate_pkg;

  // State encoding is fixed so that E/ACK decode and debug probes stay stable across revisions.
  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_WAKE = 2'd1;
  localparam logic [1:0] ST_ON   = 2'd2;
  localparam logic [1:0] ST_IDLE = 2'd3;

  // Default width of the shared wake/idle down-counter.
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    S_OFF  = ST_OFF,
    S_WAKE = ST_WAKE,
    S_ON   = ST_ON,
    S_IDLE = ST_IDLE
  } state_t;

  // Gate enable is high in every state except OFF.
  function automatic logic gate_en(input state_t s);
    return (s != S_OFF);
  endfunction

  // The gated clock is declared stable once the wake-up delay has elapsed.
  function automatic logic gate_ack(input state_t s);
    return (s == S_ON) || (s == S_IDLE);
  endfunction

endpackage

// File: rtl/clk_gate_sat_cnt.sv
// Saturating up-counter with synchronous clear; used for the gated-cycle statistic.
// Latency: count visible one edge after the increment/clear is sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
module clk_gate_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Clear wins over increment; increment stops at all-ones so the value never wraps to a misleading small number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Activity-based E/SE generator for one gated clock domain (optional stats under CLK_GATE_CTRL_STATS_EN).
// Latency: E one edge after activity from OFF, ACK WAKE_CYC edges later; E drops IDLE_CYC+1 edges after last activity.
// Backpressure: none; REQ/BUSY/FORCE are level activity hints, ACK tells the requester the clock is stable.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int WAKE_CYC = 4,
  parameter int IDLE_CYC = 8,
  parameter int CNT_W    = CNT_W_DEF
`ifdef CLK_GATE_CTRL_STATS_EN
  ,
  parameter int STAT_W   = 16
`endif
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ,
  input  logic              BUSY,
  input  logic              FORCE,
  input  logic              SCAN_EN,
  output logic              E,
  output logic              SE,
  output logic              ACK
`ifdef CLK_GATE_CTRL_STATS_EN
  ,
  input  logic              STAT_CLR,
  output logic [STAT_W-1:0] GATED_CNT
`endif
);

  // Reload values for the shared down-counter; a counter value of 0 marks the final cycle of each phase.
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             act;

  // Any of the three sources counts as activity; FORCE simply holds activity high.
  assign act = REQ | BUSY | FORCE;

  // Scan enable bypasses the controller entirely; the gate cell ORs it into its own enable.
  assign SE = SCAN_EN;

  // Next-state and counter update; WAKE deliberately ignores act so a started wake-up always completes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_OFF: begin
        if (act) begin
          state_nxt = S_WAKE;
          cnt_nxt   = WAKE_LD;
        end
      end
      S_WAKE: begin
        if (cnt == '0) begin
          state_nxt = S_ON;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_ON: begin
        if (!act) begin
          state_nxt = S_IDLE;
          cnt_nxt   = IDLE_LD;
        end
      end
      S_IDLE: begin
        // Activity on the terminal-count edge still wins: back to ON rather than OFF.
        if (act) begin
          state_nxt = S_ON;
        end else if (cnt == '0) begin
          state_nxt = S_OFF;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_OFF;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and outputs registered together; E/ACK decode the next state so they align with it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_OFF;
      cnt   <= '0;
      E     <= 1'b0;
      ACK   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      E     <= gate_en(state_nxt);
      ACK   <= gate_ack(state_nxt);
    end
  end

`ifdef CLK_GATE_CTRL_STATS_EN
  // Count every edge spent with the domain gated off.
  clk_gate_sat_cnt #(
    .W(STAT_W)
  ) u_gated_cnt (
    .clk  (CLK),
    .rst_n(RST_N),
    .clr  (STAT_CLR),
    .inc  (state == S_OFF),
    .cnt  (GATED_CNT)
  );
`else
  // Statistics build option off: no counter, no extra ports, FSM unchanged.
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: reset, wake latency, idle hysteresis, async reset, FORCE and scan.
// Latency: expectations pushed per stimulus cycle, popped and compared #1 after the following edge.
// Backpressure: n/a.
module tb_clk_gate_ctrl;

  logic CLK = 1'b0;
  logic RST_N, REQ, BUSY, FORCE, SCAN_EN;
  logic E, SE, ACK;
`ifdef CLK_GATE_CTRL_STATS_EN
  logic       STAT_CLR;
  logic [3:0] GATED_CNT;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Scoreboard of expected {E, ACK}
  logic [1:0] exp_q[$];

  always #5 CLK = ~CLK;

  clk_gate_ctrl #(
    .WAKE_CYC(4),
    .IDLE_CYC(8),
    .CNT_W   (4)
`ifdef CLK_GATE_CTRL_STATS_EN
    ,
    .STAT_W  (4)
`endif
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .REQ    (REQ),
    .BUSY   (BUSY),
    .FORCE  (FORCE),
    .SCAN_EN(SCAN_EN),
    .E      (E),
    .SE     (SE),
    .ACK    (ACK)
`ifdef CLK_GATE_CTRL_STATS_EN
    ,
    .STAT_CLR (STAT_CLR),
    .GATED_CNT(GATED_CNT)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [1:0] got;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      got = exp_q.pop_front();
      chk({tag, "_e"},   {15'd0, E},   {15'd0, got[1]});
      chk({tag, "_ack"}, {15'd0, ACK}, {15'd0, got[0]});
    end
  endtask

  // Expect {E,ACK} after the next rising edge
  task automatic cyc(input logic ee, input logic ea, input string tag);
    exp_q.push_back({ee, ea});
    @(posedge CLK);
    #1;
    sb_check(tag);
  endtask

  // Expect {E,ACK} shortly, with no clock edge in between
  task automatic now(input logic ee, input logic ea, input string tag);
    exp_q.push_back({ee, ea});
    #1;
    sb_check(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N   = 1'b1;
    REQ     = 1'b1;
    BUSY    = 1'b0;
    FORCE   = 1'b0;
    SCAN_EN = 1'b0;
`ifdef CLK_GATE_CTRL_STATS_EN
    STAT_CLR = 1'b0;
`endif
    #1;
    RST_N = 1'b0;
    now(1'b0, 1'b0, "rst_async");
    cyc(1'b0, 1'b0, "rst_req_hi0");
    cyc(1'b0, 1'b0, "rst_req_hi1");
`ifdef CLK_GATE_CTRL_STATS_EN
    chk("rst_gated_cnt", {12'd0, GATED_CNT}, 16'd0);
`endif

    // Release with REQ high: edge 0 opens the gate, single-cycle REQ pulse
    RST_N = 1'b1;
    cyc(1'b1, 1'b0, "rel_edge0");
    REQ = 1'b0;
    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, "wake");
    cyc(1'b1, 1'b1, "ack_edge4");

    // Idle hysteresis: BUSY last high at edge 10, gate closes after edge 19
    BUSY = 1'b1;
    for (int i = 5; i <= 10; i++) cyc(1'b1, 1'b1, "on_busy");
    BUSY = 1'b0;
    for (int i = 11; i <= 18; i++) cyc(1'b1, 1'b1, "idle_hold");
    cyc(1'b0, 1'b0, "idle_off_edge19");
    cyc(1'b0, 1'b0, "stay_off");

    // Same timeline, but REQ lands exactly on the terminal idle edge
    REQ = 1'b1;
    cyc(1'b1, 1'b0, "w2_edge0");
    REQ = 1'b0;
    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, "w2_wake");
    cyc(1'b1, 1'b1, "w2_ack");
    BUSY = 1'b1;
    for (int i = 5; i <= 10; i++) cyc(1'b1, 1'b1, "w2_busy");
    BUSY = 1'b0;
    for (int i = 11; i <= 18; i++) cyc(1'b1, 1'b1, "w2_idle");
    REQ = 1'b1;
    cyc(1'b1, 1'b1, "idle_rewake_edge19");
    REQ = 1'b0;
    for (int i = 20; i <= 27; i++) cyc(1'b1, 1'b1, "w2_idle2");
    cyc(1'b0, 1'b0, "w2_off_edge28");

    // Asynchronous reset during WAKE
    REQ = 1'b1;
    cyc(1'b1, 1'b0, "w3_edge0");
    REQ = 1'b0;
    cyc(1'b1, 1'b0, "w3_wake");
    #2;
    RST_N = 1'b0;
    now(1'b0, 1'b0, "rst_mid_wake");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    cyc(1'b0, 1'b0, "post_rst_wake_off");

    // Asynchronous reset during IDLE
    REQ = 1'b1;
    cyc(1'b1, 1'b0, "w4_edge0");
    REQ = 1'b0;
    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, "w4_wake");
    cyc(1'b1, 1'b1, "w4_ack");
    for (int i = 5; i <= 7; i++) cyc(1'b1, 1'b1, "w4_idle");
    #2;
    RST_N = 1'b0;
    now(1'b0, 1'b0, "rst_mid_idle");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    cyc(1'b0, 1'b0, "post_rst_idle_off");

    // FORCE held for 100 cycles with scan enable toggling
    FORCE = 1'b1;
    for (int i = 0; i < 100; i++) begin
      logic exp_se;
      exp_se  = ((i % 2) == 1);
      SCAN_EN = exp_se;
      #1;
      chk("se_follow", {15'd0, SE}, {15'd0, exp_se});
      cyc(1'b1, (i >= 4), "force");
    end
    FORCE   = 1'b0;
    SCAN_EN = 1'b0;
    for (int i = 100; i <= 107; i++) cyc(1'b1, 1'b1, "force_release_idle");
    cyc(1'b0, 1'b0, "force_release_off");

`ifdef CLK_GATE_CTRL_STATS_EN
    // Gated-cycle statistic: clear, count up, saturate at 15, clear again
    STAT_CLR = 1'b1;
    cyc(1'b0, 1'b0, "stat_pre_clr");
    chk("stat_clr0", {12'd0, GATED_CNT}, 16'd0);
    STAT_CLR = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 1'b0, "stat_idle");
      chk("stat_count", {12'd0, GATED_CNT}, 16'((k > 15) ? 15 : k));
    end
    STAT_CLR = 1'b1;
    cyc(1'b0, 1'b0, "stat_clr_cyc");
    chk("stat_clr1", {12'd0, GATED_CNT}, 16'd0);
    STAT_CLR = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
